// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder: glyph codes (g..a, active-low),
// scan FSM states and the blank-digit code.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_COUNT  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Segment-sample input and decoded-byte valid/ready stream of seg7_scan_decoder.
// SEG7_SCAN_DECODER_STATS_EN adds the saturating bad/overrun counters.
interface seg7_scan_decoder_if;
  logic        sample_en;
  logic [13:0] seg_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        bad_pattern;
  logic        overrun;
`ifdef SEG7_SCAN_DECODER_STATS_EN
  logic [7:0]  bad_cnt;
  logic [7:0]  ovr_cnt;

  modport master (input sample_en, seg_in, out_ready,
                  output out_data, out_valid, bad_pattern, overrun, bad_cnt, ovr_cnt);
  modport slave  (output sample_en, seg_in, out_ready,
                  input out_data, out_valid, bad_pattern, overrun, bad_cnt, ovr_cnt);
`else
  modport master (input sample_en, seg_in, out_ready,
                  output out_data, out_valid, bad_pattern, overrun);
  modport slave  (output sample_en, seg_in, out_ready,
                  input out_data, out_valid, bad_pattern, overrun);
`endif
endinterface

// File: rtl/seg7_scan_decoder_digit_dec.sv
// Combinational glyph-to-nibble decoder for one active-low 7-segment digit.
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nib
);

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (seg)
      GLYPH_0: nib = 4'h0;
      GLYPH_1: nib = 4'h1;
      GLYPH_2: nib = 4'h2;
      GLYPH_3: nib = 4'h3;
      GLYPH_4: nib = 4'h4;
      GLYPH_5: nib = 4'h5;
      GLYPH_6: nib = 4'h6;
      GLYPH_7: nib = 4'h7;
      GLYPH_8: nib = 4'h8;
      GLYPH_9: nib = 4'h9;
      GLYPH_A: nib = 4'hA;
      GLYPH_B: nib = 4'hB;
      GLYPH_C: nib = 4'hC;
      GLYPH_D: nib = 4'hD;
      GLYPH_E: nib = 4'hE;
      GLYPH_F: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Debounces a dual-digit active-low segment bus and streams the decoded byte (valid/ready).
// Optional SEG7_SCAN_DECODER_STATS_EN adds saturating bad_cnt / ovr_cnt outputs.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT  = 4,
  parameter int EMIT_REPEAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_scan_decoder_if.master  bus
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W:0] STABLE_V = (CNT_W + 1)'(STABLE_CNT);

  state_t           state;
  logic [13:0]      cand;
  logic [CNT_W-1:0] cnt;
  logic             last_vld;
  logic [7:0]       last_byte;
  logic [7:0]       out_data_r;
  logic             out_valid_r;
  logic             bad_r;
  logic             ovr_r;

  logic       hi_legal, lo_legal;
  logic [3:0] hi_nib, lo_nib;

  seg7_digit_dec u_hi (.seg(bus.seg_in[13:7]), .legal(hi_legal), .nib(hi_nib));
  seg7_digit_dec u_lo (.seg(bus.seg_in[6:0]),  .legal(lo_legal), .nib(lo_nib));

  logic           match;
  logic [CNT_W:0] cnt_nxt;
  logic           lock_eval;
  logic           glyph_ok;
  logic [7:0]     byte_dec;
  logic           emit;

  // Both lock paths evaluate the pattern currently on seg_in (it equals cand when counting).
  assign match     = (bus.seg_in == cand);
  assign cnt_nxt   = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign lock_eval = bus.sample_en &
                     (match ? ((state == S_COUNT) && (cnt_nxt == STABLE_V))
                            : (STABLE_CNT == 1));
  assign glyph_ok  = hi_legal & lo_legal;
  assign byte_dec  = {hi_nib, lo_nib};
  assign emit      = lock_eval & glyph_ok &
                     ((EMIT_REPEAT != 0) | ~last_vld | (byte_dec != last_byte));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_WAIT;
      cand        <= 14'h3FFF;
      cnt         <= '0;
      last_vld    <= 1'b0;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      bad_r       <= 1'b0;
      ovr_r       <= 1'b0;
    end else begin
      bad_r       <= lock_eval & ~glyph_ok;
      ovr_r       <= emit & out_valid_r & ~bus.out_ready;
      out_valid_r <= emit | (out_valid_r & ~bus.out_ready);
      if (emit) begin
        out_data_r <= byte_dec;
        last_vld   <= 1'b1;
      end
      if (bus.sample_en) begin
        if (!match) begin
          cand  <= bus.seg_in;
          cnt   <= CNT_W'(1);
          state <= (STABLE_CNT == 1) ? S_LOCKED : S_COUNT;
        end else if (state == S_COUNT) begin
          cnt <= cnt_nxt[CNT_W-1:0];
          if (cnt_nxt == STABLE_V) state <= S_LOCKED;
        end
      end
    end
  end

  // Repeat suppression reference; only meaningful once last_vld is set.
  always_ff @(posedge clk) begin
    if (emit) last_byte <= byte_dec;
  end

  assign bus.out_data    = out_data_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.bad_pattern = bad_r;
  assign bus.overrun     = ovr_r;

`ifdef SEG7_SCAN_DECODER_STATS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] bad_cnt_r, ovr_cnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_cnt_r <= 8'h00;
      ovr_cnt_r <= 8'h00;
    end else begin
      if (bad_r) bad_cnt_r <= sat_inc(bad_cnt_r);
      if (ovr_r) ovr_cnt_r <= sat_inc(ovr_cnt_r);
    end
  end

  assign bus.bad_cnt = bad_cnt_r;
  assign bus.ovr_cnt = ovr_cnt_r;
`endif

endmodule
